gen_dpram: RTL and testbench

GEN_DPRAM -- requirements
Module: gen_dpram

---
 rtl/gen_dpram_pkg.sv | 13 +
 rtl/gen_dpram_core.sv | 61 ++++++
 rtl/gen_dpram.sv | 171 +++++++++++++++++
 tb/tb_gen_dpram.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_dpram_pkg.sv
// Shared definitions for the gen_dpram dual-port RAM.
//   LANE_W  : width of one byte-enable lane
//   state_e : controller states (CLEAR = zero-fill sweep, RUN = user access)
package gen_dpram_pkg;

    localparam int LANE_W = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/gen_dpram_core.sv
// Plain dual-port storage array. It has per-lane write enables and registered
// read data. Reads return the word stored before this cycle's writes, and the
// core does no forwarding, so the array maps onto a block RAM.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset (output regs only)
//   addr_x_i, wdata_x_i     : word address and write data, port x in {a, b}
//   be_x_i, we_x_i, re_x_i  : lane enables, write strobe, read strobe
//   q_x_o                   : registered read data (holds while re_x_i = 0)
module gen_dpram_core
    import gen_dpram_pkg::*;
#(
    parameter  int AW = 8,
    parameter  int DW = 16,
    localparam int BL = DW / LANE_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [DW-1:0] wdata_a_i,
    input  logic [BL-1:0] be_a_i,
    input  logic          we_a_i,
    input  logic          re_a_i,
    output logic [DW-1:0] q_a_o,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] wdata_b_i,
    input  logic [BL-1:0] be_b_i,
    input  logic          we_b_i,
    input  logic          re_b_i,
    output logic [DW-1:0] q_b_o
);

    // NOTE: the array has no reset. Resetting it would stop block RAM
    // inference, so the zero-fill is done by the controller in the top.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q_a_q;
    logic [DW-1:0] q_b_q;

    // The top never enables the same lane on both ports for one address.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BL; i++) begin
            if (we_a_i && be_a_i[i]) mem[addr_a_i][i*LANE_W +: LANE_W] <= wdata_a_i[i*LANE_W +: LANE_W];
            if (we_b_i && be_b_i[i]) mem[addr_b_i][i*LANE_W +: LANE_W] <= wdata_b_i[i*LANE_W +: LANE_W];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            if (re_a_i) q_a_q <= mem[addr_a_i];
            if (re_b_i) q_b_q <= mem[addr_b_i];
        end
    end

    assign q_a_o = q_a_q;
    assign q_b_o = q_b_q;

endmodule

// File: rtl/gen_dpram.sv
// Dual-port RAM with a single clock and optional zero-fill after reset.
// Port A has byte enables. Port B writes full words. When both ports write
// the same address, port A wins on its enabled lanes. Reads are write-first
// on their own port. With BYPASS set, a read also sees the other port's
// same-cycle write.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   address_a, data_a, byteena_a     : port A address / write data / lane enables
//   wren_a, rden_a, q_a              : port A strobes and registered read data
//   address_b, data_b, wren_b, rden_b, q_b : port B (full-word writes)
//   ready                            : high once the array accepts user accesses
module gen_dpram
    import gen_dpram_pkg::*;
#(
    parameter  int AW           = 8,
    parameter  int DW           = 16,
    parameter  int CLR_ON_RESET = 1,
    parameter  int BYPASS       = 1,
    localparam int BL           = DW / LANE_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] address_a,
    input  logic [DW-1:0] data_a,
    input  logic [BL-1:0] byteena_a,
    input  logic          wren_a,
    input  logic          rden_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] address_b,
    input  logic [DW-1:0] data_b,
    input  logic          wren_b,
    input  logic          rden_b,
    output logic [DW-1:0] q_b,
    output logic          ready
);

    if ((DW % LANE_W) != 0 || AW < 1) begin : g_bad_param
        $error("gen_dpram: DW must be a multiple of 8 and AW must be at least 1");
    end

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;          // one spare bit flags the end of the sweep
    logic          ready_q;

    logic          user_ok, clear_wr, same_addr;
    logic          wr_a, wr_b, rd_a, rd_b;
    logic [BL-1:0] be_a_eff, be_b_eff;

    logic [AW-1:0] core_addr_a;
    logic [DW-1:0] core_wdata_a;
    logic [BL-1:0] core_be_a;
    logic          core_we_a;
    logic [DW-1:0] core_q_a, core_q_b;

    // Lanes that a read must take from the same-cycle write and not from the array.
    logic [BL-1:0] fwd_mask_a_d, fwd_mask_a_q, fwd_mask_b_d, fwd_mask_b_q;
    logic [DW-1:0] fwd_data_a_d, fwd_data_a_q, fwd_data_b_d, fwd_data_b_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
            if (cnt_d[AW]) state_d = ST_RUN;   // address 2^AW-1 is written this cycle
        end
    end

    // ---------------- FSM: outputs / access steering ----------------
    always_comb begin
        user_ok   = ready_q & ~reset;
        clear_wr  = (state_q == ST_CLEAR) & ~reset;
        wr_a      = wren_a & user_ok;
        wr_b      = wren_b & user_ok;
        rd_a      = rden_a & user_ok;
        rd_b      = rden_b & user_ok;
        same_addr = (address_a == address_b);
        be_a_eff  = wr_a ? byteena_a : '0;
        // On a collision, port B gives up the lanes that port A writes.
        be_b_eff  = wr_b ? ((wr_a && same_addr) ? ~byteena_a : '1) : '0;

        // The zero-fill sweep borrows port A. User traffic is blocked meanwhile.
        core_addr_a  = clear_wr ? cnt_q[AW-1:0] : address_a;
        core_wdata_a = clear_wr ? '0 : data_a;
        core_be_a    = clear_wr ? '1 : be_a_eff;
        core_we_a    = clear_wr | wr_a;
    end

    // ---------------- forwarding for same-cycle writes ----------------
    always_comb begin
        fwd_mask_a_d = be_a_eff;
        fwd_data_a_d = data_a;
        fwd_mask_b_d = be_b_eff;
        fwd_data_b_d = data_b;
        if (BYPASS != 0 && same_addr) begin
            for (int i = 0; i < BL; i++) begin
                if (be_b_eff[i]) begin
                    fwd_mask_a_d[i]                  = 1'b1;
                    fwd_data_a_d[i*LANE_W +: LANE_W] = data_b[i*LANE_W +: LANE_W];
                end
                if (be_a_eff[i]) begin
                    fwd_mask_b_d[i]                  = 1'b1;
                    fwd_data_b_d[i*LANE_W +: LANE_W] = data_a[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Forwarding state follows the read strobes so that q holds with the core.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_mask_a_q <= '0;
            fwd_data_a_q <= '0;
            fwd_mask_b_q <= '0;
            fwd_data_b_q <= '0;
        end else begin
            if (rd_a) begin
                fwd_mask_a_q <= fwd_mask_a_d;
                fwd_data_a_q <= fwd_data_a_d;
            end
            if (rd_b) begin
                fwd_mask_b_q <= fwd_mask_b_d;
                fwd_data_b_q <= fwd_data_b_d;
            end
        end
    end

    always_comb begin
        q_a = core_q_a;
        q_b = core_q_b;
        for (int i = 0; i < BL; i++) begin
            if (fwd_mask_a_q[i]) q_a[i*LANE_W +: LANE_W] = fwd_data_a_q[i*LANE_W +: LANE_W];
            if (fwd_mask_b_q[i]) q_b[i*LANE_W +: LANE_W] = fwd_data_b_q[i*LANE_W +: LANE_W];
        end
    end

    assign ready = ready_q;

    gen_dpram_core #(.AW(AW), .DW(DW)) u_core (
        .clk_i     (clock),
        .rst_i     (reset),
        .addr_a_i  (core_addr_a),
        .wdata_a_i (core_wdata_a),
        .be_a_i    (core_be_a),
        .we_a_i    (core_we_a),
        .re_a_i    (rd_a),
        .q_a_o     (core_q_a),
        .addr_b_i  (address_b),
        .wdata_b_i (data_b),
        .be_b_i    (be_b_eff),
        .we_b_i    (wr_b),
        .re_b_i    (rd_b),
        .q_b_o     (core_q_b)
    );

endmodule

// File: tb/tb_gen_dpram.sv
// Self-checking bench for gen_dpram. It uses two instances that share their
// inputs:
//   u_dut    : AW=4, CLR_ON_RESET=1, BYPASS=1 (main device, modelled)
//   u_dut_nb : AW=4, CLR_ON_RESET=0, BYPASS=0 (reset/bypass variants)
module tb_gen_dpram;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int BL    = DW / 8;
    localparam int DEPTH = 2**AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address_a = '0, address_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic [BL-1:0] byteena_a = '0;
    logic          wren_a = 1'b0, rden_a = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
    logic [DW-1:0] q_a, q_b, q_a_nb, q_b_nb;
    logic          ready, ready_nb;

    int checks = 0;
    int errors = 0;

    // Reference model of the main instance: the array contents and the
    // values each read port should hold.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_qa, exp_qb;

    gen_dpram #(.AW(AW), .DW(DW), .CLR_ON_RESET(1), .BYPASS(1)) u_dut (
        .clock(clock), .reset(reset),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
        .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a),
        .address_b(address_b), .data_b(data_b),
        .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b),
        .ready(ready)
    );

    gen_dpram #(.AW(AW), .DW(DW), .CLR_ON_RESET(0), .BYPASS(0)) u_dut_nb (
        .clock(clock), .reset(reset),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
        .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a_nb),
        .address_b(address_b), .data_b(data_b),
        .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b_nb),
        .ready(ready_nb)
    );

    always #5 clock = ~clock;

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0; byteena_a = '0;
    endtask

    // Releases reset and counts edges until the main instance raises ready.
    task automatic release_and_count(output int n);
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 64);
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1'b1;
        tick();
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            address_a = AW'(a); rden_a = 1'b1;
            address_b = AW'(DEPTH - 1 - a); rden_b = 1'b1;
            tick();
            checks++;
            if (q_a !== 16'h0000 || q_b !== 16'h0000) begin
                errors++;
                $display("FAIL %s addr %0d: got q_a=%h q_b=%h expected 0000/0000", tag, a, q_a, q_b);
            end
        end
        idle();
    endtask

    task automatic fill_garbage();
        for (int a = 0; a < DEPTH; a++) begin
            address_a = AW'(a); data_a = 16'($urandom) | 16'h0101; byteena_a = '1; wren_a = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        int n;
        idle();
        reset = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0 || q_a !== 16'h0 || q_b !== 16'h0 || ready_nb !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b q_a=%h q_b=%h ready_nb=%b expected 0/0000/0000/0",
                     ready, q_a, q_b, ready_nb);
        end
        reset = 1'b0;
        tick();
        n = 1;
        checks++;
        if (ready_nb !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_first_edge: got ready_nb=%b ready=%b expected 1/0", ready_nb, ready);
        end
        while (!ready && n < 64) begin
            if (n == 10) begin
                // A write and reads attempted during the clear sweep are ignored.
                address_a = '0; data_a = 16'hFFFF; byteena_a = '1; wren_a = 1'b1; rden_a = 1'b1;
                address_b = '0; rden_b = 1'b1;
                tick();
                n++;
                checks++;
                if (q_a !== 16'h0 || q_b !== 16'h0) begin
                    errors++;
                    $display("FAIL q_during_clear: got q_a=%h q_b=%h expected 0000/0000", q_a, q_b);
                end
                idle();
            end else begin
                tick();
                n++;
            end
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clear_length: got %0d cycles expected 16", n);
        end
        read_all_zero("write_during_clear");
    endtask

    task automatic test_clear_garbage();
        int n;
        fill_garbage();
        address_a = '0; rden_a = 1'b1;
        tick();
        idle();
        checks++;
        if (q_a === 16'h0000) begin
            errors++;
            $display("FAIL garbage_preload: got q_a=%h expected nonzero", q_a);
        end
        pulse_reset();
        release_and_count(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clear_after_garbage_len: got %0d cycles expected 16", n);
        end
        read_all_zero("clear_after_garbage");
    endtask

    task automatic test_restart();
        int n;
        fill_garbage();
        pulse_reset();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        release_and_count(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL restart_len: got %0d cycles expected 16", n);
        end
        read_all_zero("restart");
    endtask

    task automatic test_byte_enable();
        address_a = 4'd3; data_a = 16'hFFFF; byteena_a = 2'b11; wren_a = 1'b1;
        tick();
        data_a = 16'h1234; byteena_a = 2'b01;
        tick();
        idle();
        rden_a = 1'b1;
        tick();
        checks++;
        if (q_a !== 16'hFF34) begin
            errors++;
            $display("FAIL byteena_low: got %h expected ff34", q_a);
        end
        // Zero byte enables: write is a no-op, same-cycle read sees the old word.
        data_a = 16'h0000; byteena_a = 2'b00; wren_a = 1'b1; rden_a = 1'b1;
        tick();
        checks++;
        if (q_a !== 16'hFF34) begin
            errors++;
            $display("FAIL byteena_none: got %h expected ff34", q_a);
        end
        // Write-first on the same port: the new high lane plus the old low lane.
        data_a = 16'h5600; byteena_a = 2'b10;
        tick();
        idle();
        checks++;
        if (q_a !== 16'h5634) begin
            errors++;
            $display("FAIL write_first_same_port: got %h expected 5634", q_a);
        end
    endtask

    task automatic test_collision();
        address_a = 4'd5; data_a = 16'hAAAA; byteena_a = 2'b10; wren_a = 1'b1; rden_a = 1'b1;
        address_b = 4'd5; data_b = 16'h5555; wren_b = 1'b1;
        tick();
        idle();
        checks++;
        if (q_a !== 16'hAA55) begin
            errors++;
            $display("FAIL collision_same_cycle_read: got %h expected aa55", q_a);
        end
        rden_a = 1'b1; rden_b = 1'b1;
        tick();
        idle();
        checks++;
        if (q_a !== 16'hAA55 || q_b !== 16'hAA55) begin
            errors++;
            $display("FAIL collision_stored: got q_a=%h q_b=%h expected aa55/aa55", q_a, q_b);
        end
    endtask

    task automatic test_bypass();
        address_b = 4'd7; data_b = 16'h1111; wren_b = 1'b1;
        tick();
        idle();
        address_a = 4'd7; data_a = 16'hBEEF; byteena_a = 2'b11; wren_a = 1'b1;
        address_b = 4'd7; rden_b = 1'b1;
        tick();
        idle();
        checks++;
        if (q_b !== 16'hBEEF || q_b_nb !== 16'h1111) begin
            errors++;
            $display("FAIL cross_port_bypass: got bypass=%h nobypass=%h expected beef/1111", q_b, q_b_nb);
        end
        rden_b = 1'b1;
        tick();
        idle();
        checks++;
        if (q_b !== 16'hBEEF || q_b_nb !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_stored: got %h/%h expected beef/beef", q_b, q_b_nb);
        end
        // With no read strobe, q keeps its value while the array changes underneath.
        address_a = 4'd7; data_a = 16'h0F0F; byteena_a = 2'b11; wren_a = 1'b1; address_b = 4'd7;
        tick();
        idle();
        checks++;
        if (q_b !== 16'hBEEF) begin
            errors++;
            $display("FAIL hold_without_rden: got %h expected beef", q_b);
        end
    endtask

    task automatic test_keep_contents();
        int n;
        for (int a = 0; a < DEPTH; a++) begin
            address_b = AW'(a); data_b = 16'(a * 16'h1111); wren_b = 1'b1;
            tick();
        end
        idle();
        pulse_reset();
        release_and_count(n);
        for (int a = 0; a < DEPTH; a++) begin
            address_a = AW'(a); rden_a = 1'b1;
            tick();
            checks++;
            if (q_a_nb !== 16'(a * 16'h1111)) begin
                errors++;
                $display("FAIL keep_contents addr %0d: got %h expected %h", a, q_a_nb, 16'(a * 16'h1111));
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            address_b = AW'(a); data_b = 16'($urandom); wren_b = 1'b1;
            mem[a] = data_b;
            tick();
        end
        idle();
        for (int i = 0; i < 400; i++) begin
            address_a = AW'($urandom_range(0, 3));
            address_b = AW'($urandom_range(0, 3));
            data_a    = 16'($urandom);
            data_b    = 16'($urandom);
            byteena_a = BL'($urandom);
            wren_a    = 1'($urandom);
            wren_b    = 1'($urandom);
            rden_a    = (i == 0) ? 1'b1 : 1'($urandom);
            rden_b    = (i == 0) ? 1'b1 : 1'($urandom);
            // Port B writes first, then port A's enabled bytes overwrite it. Reads
            // see the word after this cycle's writes.
            if (wren_b) mem[address_b] = data_b;
            if (wren_a) begin
                w = mem[address_a];
                for (int l = 0; l < BL; l++)
                    if (byteena_a[l]) w[l*8 +: 8] = data_a[l*8 +: 8];
                mem[address_a] = w;
            end
            if (rden_a) exp_qa = mem[address_a];
            if (rden_b) exp_qb = mem[address_b];
            tick();
            checks++;
            if (q_a !== exp_qa || q_b !== exp_qb) begin
                errors++;
                $display("FAIL random cycle %0d: got q_a=%h q_b=%h expected %h/%h", i, q_a, q_b, exp_qa, exp_qb);
            end
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear_garbage();
        test_restart();
        test_byte_enable();
        test_collision();
        test_bypass();
        test_keep_contents();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
